// File: rtl/key_event_decoder.sv
// Key gesture classifier: turns a debounced key level into short, long, double-click
// and auto-repeat event pulses with an encoded event code.
module key_event_decoder #(
    parameter bit          KEY_ACTIVE_LOW = 1'b1,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned LONG_CYC       = 50_000_000,
    parameter int unsigned DBL_GAP_CYC    = 12_500_000,
    parameter int unsigned REPEAT_CYC     = 5_000_000,
    parameter bit          REPEAT_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       double_pulse,
    output logic       repeat_pulse,
    output logic       event_valid,
    output logic [2:0] event_code,
    output logic       key_held
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPress1   = 3'd1,
        StWait2    = 3'd2,
        StPress2   = 3'd3,
        StLongHold = 3'd4
    } state_e;

    localparam logic [2:0] EvNone   = 3'd0;
    localparam logic [2:0] EvShort  = 3'd1;
    localparam logic [2:0] EvLong   = 3'd2;
    localparam logic [2:0] EvDouble = 3'd3;
    localparam logic [2:0] EvRepeat = 3'd4;

    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] GapLast  = CNT_W'(DBL_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] RepLast  = CNT_W'(REPEAT_CYC - 1);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             pressed, pressed_d;
    logic             press_evt, rel_evt;
    logic [2:0]       evt;
    logic             cnt_clr;

    assign pressed   = KEY_ACTIVE_LOW ? ~key_in : key_in;
    assign press_evt = pressed & ~pressed_d;
    assign rel_evt   = ~pressed & pressed_d;
    assign key_held  = pressed_d;

    always_comb begin
        state_nxt = state;
        evt       = EvNone;
        cnt_clr   = 1'b0;
        case (state)
            StIdle: begin
                if (press_evt) state_nxt = StPress1;
            end
            StPress1: begin
                // Release wins over a coincident long threshold.
                if (rel_evt) begin
                    state_nxt = StWait2;
                end else if (cnt == LongLast) begin
                    state_nxt = StLongHold;
                    evt       = EvLong;
                end
            end
            StWait2: begin
                if (press_evt) begin
                    state_nxt = StPress2;
                end else if (cnt == GapLast) begin
                    state_nxt = StIdle;
                    evt       = EvShort;
                end
            end
            StPress2: begin
                if (rel_evt) begin
                    state_nxt = StIdle;
                    evt       = EvDouble;
                end
            end
            StLongHold: begin
                if (rel_evt) begin
                    state_nxt = StIdle;
                end else if (REPEAT_EN && (cnt == RepLast)) begin
                    evt     = EvRepeat;
                    cnt_clr = 1'b1;
                end
            end
            default: state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            cnt          <= '0;
            pressed_d    <= 1'b1;  // a key held through reset must be released first
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            double_pulse <= 1'b0;
            repeat_pulse <= 1'b0;
            event_valid  <= 1'b0;
            event_code   <= EvNone;
        end else begin
            pressed_d <= pressed;
            state     <= state_nxt;
            if (cnt_clr || (state_nxt != state)) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            short_pulse  <= (evt == EvShort);
            long_pulse   <= (evt == EvLong);
            double_pulse <= (evt == EvDouble);
            repeat_pulse <= (evt == EvRepeat);
            event_valid  <= (evt != EvNone);
            event_code   <= evt;
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed gestures plus random press/release segments,
// checked against a timestamp-based gesture model for REPEAT_EN=1 and REPEAT_EN=0.
module tb_key_event_decoder;

    localparam int LONG = 20;
    localparam int GAP  = 10;
    localparam int REP  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_in = 1'b1;
    logic       sp[2], lp[2], dp[2], rp[2], ev[2], kh[2];
    logic [2:0] ec[2];

    key_event_decoder #(
        .KEY_ACTIVE_LOW(1'b1), .CNT_W(32), .LONG_CYC(LONG), .DBL_GAP_CYC(GAP),
        .REPEAT_CYC(REP), .REPEAT_EN(1'b1)
    ) dut_rep (
        .clk(clk), .rst(rst), .key_in(key_in),
        .short_pulse(sp[0]), .long_pulse(lp[0]), .double_pulse(dp[0]),
        .repeat_pulse(rp[0]), .event_valid(ev[0]), .event_code(ec[0]), .key_held(kh[0])
    );

    key_event_decoder #(
        .KEY_ACTIVE_LOW(1'b1), .CNT_W(32), .LONG_CYC(LONG), .DBL_GAP_CYC(GAP),
        .REPEAT_CYC(REP), .REPEAT_EN(1'b0)
    ) dut_norep (
        .clk(clk), .rst(rst), .key_in(key_in),
        .short_pulse(sp[1]), .long_pulse(lp[1]), .double_pulse(dp[1]),
        .repeat_pulse(rp[1]), .event_valid(ev[1]), .event_code(ec[1]), .key_held(kh[1])
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Gesture model: remembers when each phase of the current gesture began and derives
    // event times arithmetically from those timestamps.
    int  edge_n;
    int  t_p1[2], t_r1[2], t_long[2];
    bit  second[2], m_pd[2];
    bit  rep_en[2] = '{1'b1, 1'b0};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            t_p1[i] = -1; t_r1[i] = -1; t_long[i] = -1;
            second[i] = 1'b0; m_pd[i] = 1'b1;
        end
    endtask

    task automatic model_clear(int i);
        t_p1[i] = -1; t_r1[i] = -1; t_long[i] = -1; second[i] = 1'b0;
    endtask

    task automatic model_step(int i, bit p, output int code);
        bit press, rel;
        press = p & ~m_pd[i];
        rel   = ~p & m_pd[i];
        code  = 0;
        if (t_long[i] >= 0) begin
            if (rel) model_clear(i);
            else if (rep_en[i] && ((edge_n - t_long[i]) % REP == 0)) code = 4;
        end else if (second[i]) begin
            if (rel) begin code = 3; model_clear(i); end
        end else if (t_r1[i] >= 0) begin
            if (press) begin second[i] = 1'b1; t_r1[i] = -1; end
            else if (edge_n - t_r1[i] == GAP) begin code = 1; model_clear(i); end
        end else if (t_p1[i] >= 0) begin
            if (rel) begin t_r1[i] = edge_n; t_p1[i] = -1; end
            else if (edge_n - t_p1[i] == LONG) begin code = 2; t_long[i] = edge_n; end
        end else if (press) begin
            t_p1[i] = edge_n;
        end
        m_pd[i] = p;
    endtask

    task automatic compare(int i, int code, bit held);
        string s;
        s = $sformatf("u%0d@%0d", i, edge_n);
        check_val({s, " code"},   32'(ec[i]), 32'(code));
        check_val({s, " valid"},  32'(ev[i]), 32'(code != 0));
        check_val({s, " short"},  32'(sp[i]), 32'(code == 1));
        check_val({s, " long"},   32'(lp[i]), 32'(code == 2));
        check_val({s, " double"}, 32'(dp[i]), 32'(code == 3));
        check_val({s, " repeat"}, 32'(rp[i]), 32'(code == 4));
        check_val({s, " held"},   32'(kh[i]), 32'(held));
    endtask

    task automatic step();
        int code;
        @(posedge clk);
        #1;
        edge_n++;
        if (rst) begin
            model_reset();
            for (int i = 0; i < 2; i++) compare(i, 0, 1'b1);
        end else begin
            for (int i = 0; i < 2; i++) begin
                model_step(i, ~key_in, code);
                compare(i, code, m_pd[i]);
            end
        end
    endtask

    task automatic hold(bit prs, int n);
        key_in = ~prs;
        repeat (n) step();
    endtask

    task automatic async_reset_check();
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) compare(i, 0, 1'b1);
    endtask

    initial begin
        edge_n = 0;
        model_reset();
        rst = 1'b1; key_in = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        hold(1'b0, 50);

        // Short press, then double click.
        hold(1'b1, 5); hold(1'b0, 20);
        hold(1'b1, 5); hold(1'b0, 4); hold(1'b1, 3); hold(1'b0, 20);

        // Long hold: long at 20, repeats at 25/30/35 on the repeat-enabled unit only.
        hold(1'b1, 36); hold(1'b0, 20);

        // Reset mid-PRESS1 with the key still down.
        hold(1'b1, 10);
        async_reset_check();
        hold(1'b1, 3);
        rst = 1'b0;
        hold(1'b1, 30); hold(1'b0, 3); hold(1'b1, 21); hold(1'b0, 20);

        // Release on the long-threshold cycle, then second press on the gap-timeout cycle.
        hold(1'b1, 20); hold(1'b0, 20);
        hold(1'b1, 5); hold(1'b0, 10); hold(1'b1, 3); hold(1'b0, 15);

        // Random gesture segments with occasional asynchronous reset.
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 14) == 0) begin
                async_reset_check();
                hold(k[0], $urandom_range(1, 3));
                rst = 1'b0;
            end
            hold(k[0], $urandom_range(1, 30));
        end
        hold(1'b0, 25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Sits directly downstream of the key debouncer and consumes its debounced level output `key_out`, wired to this block's `key_in`.
- Classifies each key gesture as a short press, long press, double click or auto-repeat while held.
- Emits one-cycle registered event pulses plus an encoded event code for the control logic further downstream.
- All timing is in clock cycles of the system clock.

Parameters:
- KEY_ACTIVE_LOW, 1, 1: `key_in`=0 means pressed. 0: `key_in`=1 means pressed.
- CNT_W, 32, width of the internal cycle counter. Must hold the largest cycle parameter.
- LONG_CYC, 50_000_000, press duration in cycles at which a long press is declared.
- DBL_GAP_CYC, 12_500_000, maximum released gap in cycles after the first press for a second press to count as a double click.
- REPEAT_CYC, 5_000_000, repeat period in cycles while the key is held after a long press.
- REPEAT_EN, 1, 1 enables repeat_pulse generation. 0 suppresses it.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- key_in  input  1  debounced key level from the debouncer. Already synchronous and glitch-free.
- short_pulse  output  1  one-cycle pulse: short press confirmed.
- long_pulse  output  1  one-cycle pulse: long press threshold reached.
- double_pulse  output  1  one-cycle pulse: double click completed.
- repeat_pulse  output  1  one-cycle pulse: auto-repeat tick.
- event_valid  output  1  one-cycle pulse, high whenever any of the four pulses is high.
- event_code  output  3  0 none, 1 short, 2 long, 3 double, 4 repeat. Nonzero only while event_valid=1.
- key_held  output  1  registered pressed level (pressed_d).

Behaviour:
- Internal signal `pressed`: equals `~key_in` if KEY_ACTIVE_LOW, else `key_in`.
- `pressed_d` register: pressed_d <= pressed every cycle.
- press_evt = pressed & ~pressed_d. rel_evt = ~pressed & pressed_d.
- Reset (async, rst=1), effective immediately:
  - state=IDLE, cnt=0.
  - All pulses, event_valid and event_code = 0.
  - pressed_d=1, so a key held through reset produces no event until it is released and pressed again. key_held therefore reads 1 during reset.
- Counter: cnt clears to 0 on every state change and increments by 1 each cycle otherwise. It saturates at all-ones and never wraps.
- States:
  - IDLE: press_evt -> PRESS1.
  - PRESS1:
    - rel_evt -> WAIT2.
    - Else if cnt==LONG_CYC-1 -> LONG_HOLD and emit long.
    - Release takes priority if it coincides with the threshold.
  - WAIT2:
    - press_evt -> PRESS2.
    - Else if cnt==DBL_GAP_CYC-1 -> IDLE and emit short.
    - Press takes priority on the same-cycle tie.
  - PRESS2: rel_evt -> IDLE and emit double. No long detection in this state, however long the key is held.
  - LONG_HOLD:
    - rel_evt -> IDLE with no event.
    - Else if REPEAT_EN and cnt==REPEAT_CYC-1: emit repeat and clear cnt, staying in LONG_HOLD.
- Event outputs:
  - Each pulse is registered and asserts on the clock edge that performs the corresponding transition.
  - Each pulse lasts exactly one cycle, with event_valid and event_code coincident.
  - At most one event is emitted per cycle.
- Latency, counted from PRESS1 entry (the edge after the press is seen on key_in):
  - long_pulse asserts exactly LONG_CYC cycles after entry.
  - short_pulse asserts DBL_GAP_CYC cycles after WAIT2 entry.
  - double_pulse asserts 1 cycle after the second release is seen on key_in.
  - First repeat_pulse asserts REPEAT_CYC cycles after long_pulse. Subsequent ones follow every REPEAT_CYC cycles.
- The state encoding must be complete. Unused encodings return to IDLE with no event.
- key_in is never re-synchronised in this block; that is the upstream debouncer's job.

Test Plan (LONG_CYC=20, DBL_GAP_CYC=10, REPEAT_CYC=5, KEY_ACTIVE_LOW=1, REPEAT_EN=1):
- Reset with key_in=1, release rst, idle 50 cycles -> all outputs 0, event_code=0, key_held=0 one cycle after release.
- Press for 5 cycles, then release -> short_pulse=1, event_code=1 for one cycle, exactly 10 cycles after WAIT2 entry; no other pulse.
- Press 5 cycles, release 4 cycles, press 3 cycles, release -> double_pulse=1, event_code=3 one cycle after the second release; no short_pulse ever.
- Hold for 36 cycles from PRESS1 entry, then release -> long_pulse at cycle 20, repeat_pulse at cycles 25, 30, 35 (event_code 2 then 4,4,4); nothing after release.
- Rerun the previous hold with REPEAT_EN=0 -> long_pulse only, no repeat_pulse.
- Assert rst mid-PRESS1 at cycle 10 while keeping key_in=0, then deassert -> all outputs 0 immediately, no long_pulse while still held. A later release plus press for 20 cycles -> long_pulse.
- Release exactly on the cycle cnt==LONG_CYC-1 -> no long_pulse; WAIT2 path followed, short_pulse 10 cycles later.
